// File: rtl/fibonacci_gen.sv
// fibonacci_gen: free-running Fibonacci term generator.
// Presents F(0)=0 after reset, then one term per rising clock edge.
// When the next term no longer fits in WIDTH bits, the sequence restarts at 0.
// Optional build macro FIB_HOLD_AT_MAX_EN: instead of restarting, hold the
// largest representable term on f until reset.
module fibonacci_gen #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] f
);

  // Current term. The declaration value gives a valid sequence from
  // power-up even if reset is never sampled high.
  logic [WIDTH-1:0] cur_reg = '0;

  // Next term, one bit wider than f: the extra MSB flags that the next
  // term would not fit in WIDTH bits.
  logic [WIDTH:0]   nxt_reg = {{WIDTH{1'b0}}, 1'b1};

  // Overflow indicator: the term after cur_reg is not representable.
  logic             overflow;

  assign overflow = nxt_reg[WIDTH];

  // Advance one term per edge; reset wins over overflow handling.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_reg <= '0;
      nxt_reg <= {{WIDTH{1'b0}}, 1'b1};
    end else if (overflow) begin
`ifdef FIB_HOLD_AT_MAX_EN
      // Park on the largest representable term until reset.
      cur_reg <= cur_reg;
      nxt_reg <= nxt_reg;
`else
      // Restart the sequence; the overflowing term is never shown on f.
      cur_reg <= '0;
      nxt_reg <= {{WIDTH{1'b0}}, 1'b1};
`endif
    end else begin
      // Both operands are below 2^WIDTH, so the WIDTH+1 bit sum never wraps.
      cur_reg <= nxt_reg[WIDTH-1:0];
      nxt_reg <= {1'b0, cur_reg} + nxt_reg;
    end
  end

  // Output comes straight from the flop: glitch-free, no path from reset.
  assign f = cur_reg;

endmodule

// File: tb/tb_fibonacci_gen.sv
// Testbench for fibonacci_gen: two instances (WIDTH=14 and WIDTH=4) with
// independent resets, a table of directed vectors, hand-written corner
// sequences and a randomized-reset run against a term-list reference model.
module tb_fibonacci_gen;

  logic        clk = 1'b0;
  logic        rst14 = 1'b0;
  logic        rst4 = 1'b0;
  logic [13:0] f14;
  logic [3:0]  f4;

  int total = 0;
  int bad = 0;

  // Reference model: list of all representable terms plus an index.
  int fib14[$];
  int fib4[$];
  int k14 = 0;
  int k4 = 0;

  typedef struct {
    bit r14;
    bit r4;
    int e14;
    int e4;
  } vec_t;

  vec_t vecs[24];

  fibonacci_gen #(.WIDTH(14)) u14 (
    .clk   (clk),
    .reset (rst14),
    .f     (f14)
  );

  fibonacci_gen #(.WIDTH(4)) u4 (
    .clk   (clk),
    .reset (rst4),
    .f     (f4)
  );

  // Period 10, first rising edge at t=5.
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Every term from F(0) upward that is strictly below 2^w.
  task automatic build_list(input int w, output int lst[$]);
    longint a, b, t;
    lst = {};
    a = 0;
    b = 1;
    while (a < (longint'(1) << w)) begin
      lst.push_back(int'(a));
      t = a + b;
      a = b;
      b = t;
    end
  endtask

  function automatic int next_index(input int k, input int len, input bit r);
    if (r) return 0;
    if (k == len - 1) begin
`ifdef FIB_HOLD_AT_MAX_EN
      return k;
`else
      return 0;
`endif
    end
    return k + 1;
  endfunction

  // Drive resets, take one rising edge, advance the model, settle to the
  // falling edge where outputs are sampled.
  task automatic tick(input bit r14, input bit r4);
    rst14 = r14;
    rst4  = r4;
    @(posedge clk);
    k14 = next_index(k14, fib14.size(), r14);
    k4  = next_index(k4, fib4.size(), r4);
    @(negedge clk);
  endtask

  initial begin
    int max14;
    bit seen_17711;
    int exp_tail[4];

    build_list(14, fib14);
    build_list(4, fib4);

    // Directed table: power-up run, single-edge reset at f=55 (WIDTH=14
    // only), then a 3-edge reset on both instances.
    vecs[0]  = '{0, 0, 1, 1};
    vecs[1]  = '{0, 0, 1, 1};
    vecs[2]  = '{0, 0, 2, 2};
    vecs[3]  = '{0, 0, 3, 3};
    vecs[4]  = '{0, 0, 5, 5};
    vecs[5]  = '{0, 0, 8, 8};
    vecs[6]  = '{0, 0, 13, 13};
    vecs[7]  = '{0, 0, 21, 0};
    vecs[8]  = '{0, 0, 34, 1};
    vecs[9]  = '{0, 0, 55, 1};
    vecs[10] = '{1, 0, 0, 2};
    vecs[11] = '{0, 0, 1, 3};
    vecs[12] = '{0, 0, 1, 5};
    vecs[13] = '{0, 0, 2, 8};
    vecs[14] = '{0, 0, 3, 13};
    vecs[15] = '{0, 0, 5, 0};
    vecs[16] = '{1, 1, 0, 0};
    vecs[17] = '{1, 1, 0, 0};
    vecs[18] = '{1, 1, 0, 0};
    vecs[19] = '{0, 0, 1, 1};
    vecs[20] = '{0, 0, 1, 1};
    vecs[21] = '{0, 0, 2, 2};
    vecs[22] = '{0, 0, 3, 3};
    vecs[23] = '{0, 0, 5, 5};

    // Power-up value before any edge, no reset ever sampled.
    #1;
    check("powerup_f14", int'(f14), 0);
    check("powerup_f4", int'(f4), 0);
    check("model_len14", fib14.size(), 22);
    check("model_len4", fib4.size(), 8);

    for (int i = 0; i < 24; i++) begin
      tick(vecs[i].r14, vecs[i].r4);
      $display("vec %0d: r14=%0d r4=%0d f14=%0d f4=%0d", i, vecs[i].r14, vecs[i].r4, f14, f4);
      check($sformatf("vec%0d_f14", i), int'(f14), vecs[i].e14);
      check($sformatf("vec%0d_f4", i), int'(f4), vecs[i].e4);
    end

    // Wrap / hold run on WIDTH=14: reset, then 25 edges.
    tick(1, 1);
    check("wrap_reset_f14", int'(f14), 0);
    max14 = 0;
    seen_17711 = 0;
`ifdef FIB_HOLD_AT_MAX_EN
    exp_tail = '{10946, 10946, 10946, 10946};
`else
    exp_tail = '{0, 1, 1, 2};
`endif
    for (int e = 1; e <= 25; e++) begin
      tick(0, 0);
      $display("wrap edge %0d: f14=%0d", e, f14);
      if (int'(f14) > max14) max14 = int'(f14);
      if (int'(f14) == 17711) seen_17711 = 1;
      if (e == 20) check("wrap_6765", int'(f14), 6765);
      else if (e == 21) check("wrap_10946", int'(f14), 10946);
      else if (e >= 22) check($sformatf("wrap_tail%0d", e), int'(f14), exp_tail[e-22]);
      else check($sformatf("wrap_edge%0d", e), int'(f14), fib14[e]);
    end
    check("wrap_max", max14, 10946);
    check("wrap_no_17711", int'(seen_17711), 0);

    // Reset after the wrap/hold run restarts the sequence.
    tick(1, 0);
    check("post_reset_f14", int'(f14), 0);
    tick(0, 0);
    check("post_reset_1a", int'(f14), 1);
    tick(0, 0);
    check("post_reset_1b", int'(f14), 1);
    tick(0, 0);
    check("post_reset_2", int'(f14), 2);

    // Reset pulse confined between edges on WIDTH=4 must be ignored.
    for (int p = 0; p < 3; p++) begin
      int exp4;
      exp4 = fib4[next_index(k4, fib4.size(), 1'b0)];
      #1 rst4 = 1'b1;
      #2 rst4 = 1'b0;
      tick(0, 0);
      $display("glitch pulse %0d: f4=%0d", p, f4);
      check($sformatf("subperiod_pulse%0d", p), int'(f4), exp4);
    end

    // Randomized resets on both instances against the model.
    for (int n = 0; n < 300; n++) begin
      bit r14, r4;
      r14 = ($urandom_range(15) == 0);
      r4  = ($urandom_range(15) == 0);
      tick(r14, r4);
      $display("rand %0d: r14=%0d r4=%0d f14=%0d f4=%0d", n, r14, r4, f14, f4);
      check($sformatf("rand%0d_f14", n), int'(f14), fib14[k14]);
      check($sformatf("rand%0d_f4", n), int'(f4), fib4[k4]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
